// File: rtl/intellight_cu_pkg.sv
// -----------------------------------------------------------------------------
// intellight_cu_pkg
// Shared definitions for the Intellight Q-learning accelerator:
//   - state_e   : 5-bit control-unit state codes (L0..L14 = 0..14, IDLE = 15,
//                 INIT = 16, DONE = 17). Codes 18..31 are unused.
//   - LFSR_TAP  : feedback mask of the 16-bit right-shifting Galois LFSR.
//   - NUM_L_STATES : length of the per-step learning pipeline.
// -----------------------------------------------------------------------------
package intellight_cu_pkg;

    typedef enum logic [4:0] {
        ST_L0   = 5'd0,
        ST_L1   = 5'd1,
        ST_L2   = 5'd2,
        ST_L3   = 5'd3,
        ST_L4   = 5'd4,
        ST_L5   = 5'd5,
        ST_L6   = 5'd6,
        ST_L7   = 5'd7,
        ST_L8   = 5'd8,
        ST_L9   = 5'd9,
        ST_L10  = 5'd10,
        ST_L11  = 5'd11,
        ST_L12  = 5'd12,
        ST_L13  = 5'd13,
        ST_L14  = 5'd14,
        ST_IDLE = 5'd15,
        ST_INIT = 5'd16,
        ST_DONE = 5'd17
    } state_e;

    localparam logic [15:0] LFSR_TAP     = 16'hB400;
    localparam int          NUM_L_STATES = 15;

endpackage

// File: rtl/intellight_cu_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Right-shifting Galois LFSR used for epsilon-greedy exploration.
//   clk     in  clock, rising edge
//   rst     in  asynchronous active-low reset (register resets to 1)
//   load_i  in  load seed_i (a zero seed is replaced by 1 so the LFSR can
//               never lock up in the all-zero state)
//   en_i    in  advance one shift
//   seed_i  in  WIDTH  seed value
//   next_o  out WIDTH  value the register takes on the next enabled shift
// -----------------------------------------------------------------------------
module lfsr16
    import intellight_cu_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAP   = LFSR_TAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] next_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    // Galois form: shift right, fold the tap mask in when a 1 falls out.
    assign next_o = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAP) : (lfsr_q >> 1);

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == '0) ? ONE : seed_i;
        end else if (en_i) begin
            lfsr_d = next_o;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= ONE;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/intellight_cu.sv
// -----------------------------------------------------------------------------
// intellight_cu
// Control unit of the Intellight Q-learning accelerator. Sequences
// epsilon-greedy training as an episode loop around a step loop, each step
// being the fixed 15-state pipeline L0..L14.
//   clk            in  clock, rising edge
//   rst            in  asynchronous active-low reset
//   run            in  level start request (only sampled in IDLE and DONE)
//   mode           in  0 = train, 1 = inference (latched in INIT)
//   max_step       in  steps per episode (latched in INIT, 0 treated as 1)
//   max_episode    in  episodes (latched in INIT, 0 treated as 1)
//   seed           in  LFSR seed (latched in INIT, 0 treated as 1)
//   A_sel          out 1 = random action, 0 = greedy action
//   wen            out Q-table write enable, one cycle in L12 (train only)
//   finish         out high in DONE
//   idle           out high in IDLE
//   debug_step     out current step counter
//   debug_episode  out current episode counter
//   debug_epsilon  out current exploration rate
//   debug_cs       out current state code
//   debug_ns       out next state code (combinational)
// CTR_WIDTH must equal RND_WIDTH: the LFSR value is compared directly
// against epsilon.
// -----------------------------------------------------------------------------
module intellight_cu
    import intellight_cu_pkg::*;
#(
    parameter int                   RND_WIDTH = 16,
    parameter int                   CTR_WIDTH = 16,
    parameter logic [CTR_WIDTH-1:0] EPS_INIT  = 16'hFFFF,
    parameter logic [CTR_WIDTH-1:0] EPS_DEC   = 16'd655
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 mode,
    input  logic [CTR_WIDTH-1:0] max_step,
    input  logic [CTR_WIDTH-1:0] max_episode,
    input  logic [RND_WIDTH-1:0] seed,
    output logic                 A_sel,
    output logic                 wen,
    output logic                 finish,
    output logic                 idle,
    output logic [CTR_WIDTH-1:0] debug_step,
    output logic [CTR_WIDTH-1:0] debug_episode,
    output logic [CTR_WIDTH-1:0] debug_epsilon,
    output logic [4:0]           debug_cs,
    output logic [4:0]           debug_ns
);

    localparam logic [CTR_WIDTH-1:0] ONE = {{(CTR_WIDTH-1){1'b0}}, 1'b1};

    state_e                 cs_q;
    state_e                 ns_d;
    logic [CTR_WIDTH-1:0]   step_q;
    logic [CTR_WIDTH-1:0]   episode_q;
    logic [CTR_WIDTH-1:0]   eps_q;
    logic [CTR_WIDTH-1:0]   max_step_q;
    logic [CTR_WIDTH-1:0]   max_episode_q;
    logic                   mode_q;
    logic                   a_sel_q;
    logic                   wen_q;
    logic                   finish_q;
    logic                   idle_q;
    logic [RND_WIDTH-1:0]   lfsr_next;
    logic                   step_last;
    logic                   episode_last;

    // The LFSR is reloaded in INIT and shifted once per step in L0; the
    // shifted value is what the exploration decision compares against.
    lfsr16 #(
        .WIDTH (RND_WIDTH)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (cs_q == ST_INIT),
        .en_i   (cs_q == ST_L0),
        .seed_i (seed),
        .next_o (lfsr_next)
    );

    // Latched limits are never 0, so "limit - 1" cannot underflow.
    assign step_last    = !(step_q    < (max_step_q    - ONE));
    assign episode_last = !(episode_q < (max_episode_q - ONE));

    always_comb begin
        ns_d = ST_IDLE;
        case (cs_q)
            ST_IDLE: ns_d = run ? ST_INIT : ST_IDLE;
            ST_INIT: ns_d = ST_L0;
            ST_L14:  ns_d = (step_last && episode_last) ? ST_DONE : ST_L0;
            ST_DONE: ns_d = run ? ST_DONE : ST_IDLE;
            default: begin
                // L0..L13 walk forward; unused codes 18..31 fall back to IDLE.
                if (cs_q < ST_L14) begin
                    ns_d = state_e'(cs_q + 5'd1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_q          <= ST_IDLE;
            step_q        <= '0;
            episode_q     <= '0;
            eps_q         <= EPS_INIT;
            max_step_q    <= ONE;
            max_episode_q <= ONE;
            mode_q        <= 1'b0;
            a_sel_q       <= 1'b0;
            wen_q         <= 1'b0;
            finish_q      <= 1'b0;
            idle_q        <= 1'b1;
        end else begin
            cs_q     <= ns_d;
            // Moore outputs are registered from the next state so they line
            // up exactly with the state they belong to.
            idle_q   <= (ns_d == ST_IDLE);
            finish_q <= (ns_d == ST_DONE);
            wen_q    <= (ns_d == ST_L12) && !mode_q;

            case (cs_q)
                ST_INIT: begin
                    step_q        <= '0;
                    episode_q     <= '0;
                    eps_q         <= EPS_INIT;
                    mode_q        <= mode;
                    max_step_q    <= (max_step    == '0) ? ONE : max_step;
                    max_episode_q <= (max_episode == '0) ? ONE : max_episode;
                    a_sel_q       <= 1'b0;
                end
                ST_L0: begin
                    a_sel_q <= !mode_q && (lfsr_next < eps_q);
                end
                ST_L14: begin
                    if (!step_last) begin
                        step_q <= step_q + ONE;
                    end else begin
                        step_q <= '0;
                        if (!episode_last) begin
                            episode_q <= episode_q + ONE;
                            // Saturating decay; inference keeps epsilon fixed.
                            if (!mode_q) begin
                                eps_q <= (eps_q > EPS_DEC) ? (eps_q - EPS_DEC) : '0;
                            end
                        end else begin
                            a_sel_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign A_sel         = a_sel_q;
    assign wen           = wen_q;
    assign finish        = finish_q;
    assign idle          = idle_q;
    assign debug_step    = step_q;
    assign debug_episode = episode_q;
    assign debug_epsilon = eps_q;
    assign debug_cs      = cs_q;
    assign debug_ns      = ns_d;

endmodule

// File: tb/tb_intellight_cu.sv
// -----------------------------------------------------------------------------
// tb_intellight_cu
// Self-checking bench for intellight_cu: a table of training runs, each with
// its expected cycle count, write-pulse count and final epsilon, plus a
// per-step scoreboard filled from a software model of the learning loop, and
// a hand-written asynchronous-reset-in-L7 sequence.
// -----------------------------------------------------------------------------
module tb_intellight_cu;

    localparam logic [15:0] EPS_INIT = 16'hFFFF;
    localparam logic [15:0] EPS_DEC  = 16'd655;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] max_step = 16'd1;
    logic [15:0] max_episode = 16'd1;
    logic [15:0] seed = 16'd1;
    logic        A_sel, wen, finish, idle;
    logic [15:0] debug_step, debug_episode, debug_epsilon;
    logic [4:0]  debug_cs, debug_ns;

    intellight_cu #(
        .RND_WIDTH (16),
        .CTR_WIDTH (16),
        .EPS_INIT  (EPS_INIT),
        .EPS_DEC   (EPS_DEC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .mode          (mode),
        .max_step      (max_step),
        .max_episode   (max_episode),
        .seed          (seed),
        .A_sel         (A_sel),
        .wen           (wen),
        .finish        (finish),
        .idle          (idle),
        .debug_step    (debug_step),
        .debug_episode (debug_episode),
        .debug_epsilon (debug_epsilon),
        .debug_cs      (debug_cs),
        .debug_ns      (debug_ns)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic        mode;
        logic [15:0] ms;
        logic [15:0] me;
        logic [15:0] seed;
        logic        drop_run;
        int          exp_cycles;
        int          exp_wen;
        logic [15:0] exp_eps;
    } vec_t;

    typedef struct {
        logic [15:0] step;
        logic [15:0] episode;
        logic [15:0] eps;
        logic        asel;
    } step_t;

    step_t sb_q[$];
    vec_t  vecs[6];

    // Software model of the whole training run, pushed step by step.
    task automatic build_model(input vec_t v);
        logic [15:0] l;
        logic [15:0] eps;
        int ms, me;
        l   = (v.seed == 16'd0) ? 16'd1 : v.seed;
        ms  = (v.ms == 16'd0) ? 1 : int'(v.ms);
        me  = (v.me == 16'd0) ? 1 : int'(v.me);
        eps = EPS_INIT;
        sb_q.delete();
        for (int e = 0; e < me; e++) begin
            for (int s = 0; s < ms; s++) begin
                step_t it;
                if (l[0]) l = (l >> 1) ^ 16'hB400;
                else      l = l >> 1;
                it.step    = 16'(s);
                it.episode = 16'(e);
                it.eps     = eps;
                it.asel    = !v.mode && (l < eps);
                sb_q.push_back(it);
            end
            if (e < me - 1 && !v.mode) begin
                if (eps > EPS_DEC) eps = eps - EPS_DEC;
                else               eps = 16'd0;
            end
        end
    endtask

    task automatic check_reset_state(input string tag, input logic exp_ns_run);
        check({tag, "_idle"},   idle,          1);
        check({tag, "_finish"}, finish,        0);
        check({tag, "_wen"},    wen,           0);
        check({tag, "_asel"},   A_sel,         0);
        check({tag, "_step"},   debug_step,    0);
        check({tag, "_ep"},     debug_episode, 0);
        check({tag, "_eps"},    debug_epsilon, EPS_INIT);
        check({tag, "_cs"},     debug_cs,      15);
        check({tag, "_ns"},     debug_ns,      exp_ns_run ? 16 : 15);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          cyc = 0;
        int          wen_cnt = 0;
        int          budget;
        bit          wen_bad = 0;
        bit          asel_bad = 0;
        bit          eps_up = 0;
        bit          got_finish = 0;
        logic [15:0] prev_eps;
        step_t       it;
        build_model(v);
        budget = 15 * ((v.ms == 0) ? 1 : int'(v.ms)) * ((v.me == 0) ? 1 : int'(v.me)) + 50;

        rst = 1'b0; run = 1'b0;
        mode = v.mode; max_step = v.ms; max_episode = v.me; seed = v.seed;
        @(posedge clk); #1;
        check_reset_state($sformatf("v%0d_rst", idx), 1'b0);
        rst = 1'b1; run = 1'b1;
        #1;
        check($sformatf("v%0d_ns_run", idx), debug_ns, 16);
        prev_eps = debug_epsilon;

        while (!got_finish && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (v.drop_run && cyc == 5) begin
                // Mid-training input changes must all be ignored.
                run = 1'b0; max_step = 16'd7; max_episode = 16'd9; mode = ~v.mode;
            end
            if (debug_cs == 5'd1) begin
                if (sb_q.size() == 0) begin
                    check($sformatf("v%0d_extra_step", idx), 1, 0);
                end else begin
                    it = sb_q.pop_front();
                    check($sformatf("v%0d_step", idx),    debug_step,    it.step);
                    check($sformatf("v%0d_episode", idx), debug_episode, it.episode);
                    check($sformatf("v%0d_eps", idx),     debug_epsilon, it.eps);
                    check($sformatf("v%0d_asel", idx),    A_sel,         it.asel);
                end
            end
            if (v.mode && A_sel) asel_bad = 1;
            if (wen) begin
                wen_cnt++;
                if (debug_cs != 5'd12) wen_bad = 1;
            end
            if (debug_epsilon > prev_eps) eps_up = 1;
            prev_eps = debug_epsilon;
            if (finish) got_finish = 1;
        end

        if (!got_finish) $display("FAIL v%0d_timeout: got no finish, expected finish by cycle %0d", idx, budget);
        check($sformatf("v%0d_cycles", idx),     cyc,           v.exp_cycles);
        check($sformatf("v%0d_done_cs", idx),    debug_cs,      17);
        check($sformatf("v%0d_wen_cnt", idx),    wen_cnt,       v.exp_wen);
        check($sformatf("v%0d_wen_in_l12", idx), wen_bad,       0);
        check($sformatf("v%0d_asel_inf", idx),   asel_bad,      0);
        check($sformatf("v%0d_eps_final", idx),  debug_epsilon, v.exp_eps);
        check($sformatf("v%0d_eps_mono", idx),   eps_up,        0);
        check($sformatf("v%0d_sb_empty", idx),   sb_q.size(),   0);

        if (!v.drop_run) begin
            @(posedge clk); #1;
            check($sformatf("v%0d_finish_hold", idx), finish, 1);
            run = 1'b0;
        end
        @(posedge clk); #1;
        check($sformatf("v%0d_back_idle", idx), idle, 1);
        check($sformatf("v%0d_finish_low", idx), finish, 0);
        $display("vec %0d: mode=%0d steps=%0d episodes=%0d seed=%0h cycles=%0d wen=%0d eps=%0h",
                 idx, v.mode, v.ms, v.me, v.seed, cyc, wen_cnt, debug_epsilon);
    endtask

    initial begin
        int waited;
        // {mode, max_step, max_episode, seed, drop_run, cycles, wen pulses, final eps}
        vecs[0] = '{1'b0, 16'd4, 16'd2,   16'd612,  1'b0, 122,  8,   16'hFD70};
        vecs[1] = '{1'b1, 16'd4, 16'd2,   16'd612,  1'b0, 122,  0,   16'hFFFF};
        vecs[2] = '{1'b0, 16'd3, 16'd3,   16'd0,    1'b0, 137,  9,   16'hFAE1};
        vecs[3] = '{1'b0, 16'd0, 16'd0,   16'd5,    1'b0, 17,   1,   16'hFFFF};
        vecs[4] = '{1'b0, 16'd2, 16'd3,   16'hACE1, 1'b1, 92,   6,   16'hFAE1};
        vecs[5] = '{1'b0, 16'd1, 16'd110, 16'd612,  1'b0, 1652, 110, 16'h0000};

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Asynchronous reset while in L7, with run held high for a restart.
        rst = 1'b0; run = 1'b0;
        mode = 1'b0; max_step = 16'd4; max_episode = 16'd2; seed = 16'd612;
        @(posedge clk); #1;
        rst = 1'b1; run = 1'b1;
        waited = 0;
        while (debug_cs != 5'd7 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check("l7_reached", debug_cs, 7);
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("l7_async", 1'b1);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        check("restart_init", debug_cs, 16);
        @(posedge clk); #1;
        check("restart_l0", debug_cs, 0);
        check("restart_idle_low", idle, 0);
        $display("reset-in-L7: waited=%0d cs_after_restart=%0d", waited, debug_cs);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
